// File: rtl/join_shift_jump_pkg.sv
// Shared MIPS address-formation constants and types.
package mips_pkg;
    localparam int JUMP_FIELD_W = 28;
    localparam int JUMP_INDEX_W = 26;
    localparam int REGION_W     = 4;
    localparam int ADDR_W       = 32;

    typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/join_shift_jump_if.sv
// Jump-target request/result bundle between decoder side and PC-select side.
interface join_shift_jump_if;
    import mips_pkg::*;

    logic                    in_valid;
    logic                    shift_en;
    logic [JUMP_FIELD_W-1:0] in1;
    logic [REGION_W-1:0]     in2;
    addr_t                   out;
    logic                    out_valid;
    logic                    misaligned;

    // Producer of the jump field, consumer of the target.
    modport master (
        output in_valid, shift_en, in1, in2,
        input  out, out_valid, misaligned
    );

    // The target former itself.
    modport slave (
        input  in_valid, shift_en, in1, in2,
        output out, out_valid, misaligned
    );
endinterface

// File: rtl/join_shift_jump_comb.sv
// Combinational pseudo-direct target: {region, low28}, plus alignment flag.
module jump_target_comb
    import mips_pkg::*;
#(
    parameter int REGION_W = mips_pkg::REGION_W
) (
    input  logic                             i_shift_en,
    input  logic [JUMP_FIELD_W-1:0]          i_in1,
    input  logic [REGION_W-1:0]              i_in2,
    output logic [REGION_W+JUMP_FIELD_W-1:0] o_target,
    output logic                             o_mis
);
    logic [JUMP_FIELD_W-1:0] w_low;

    // Word index mode drops in1[27:26] and scales by 4; byte mode passes through.
    // A misaligned byte offset is only flagged, the target is left as given.
    always_comb begin
        w_low    = i_shift_en ? {i_in1[JUMP_INDEX_W-1:0], 2'b00} : i_in1;
        o_target = {i_in2, w_low};
        o_mis    = ~i_shift_en & (i_in1[1:0] != 2'b00);
    end
endmodule

// File: rtl/join_shift_jump.sv
// Jump-target former with optional one-cycle output register.
module join_shift_jump
    import mips_pkg::*;
#(
    parameter bit REGISTERED = 1'b1,
    parameter int REGION_W   = mips_pkg::REGION_W
) (
    input  logic              clk,
    input  logic              rst_n,
    join_shift_jump_if.slave  bus
);
    addr_t               w_target;
    logic                w_mis;
    logic [REGION_W-1:0] w_region;

    assign w_region = bus.in2;

    jump_target_comb #(.REGION_W(REGION_W)) u_comb (
        .i_shift_en (bus.shift_en),
        .i_in1      (bus.in1),
        .i_in2      (w_region),
        .o_target   (w_target),
        .o_mis      (w_mis)
    );

    if (REGISTERED) begin : g_reg
        addr_t r_out;
        logic  r_out_valid;
        logic  r_mis;

        // Capture only on valid so X on idle inputs never reaches the outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_out       <= '0;
                r_out_valid <= 1'b0;
                r_mis       <= 1'b0;
            end else begin
                r_out_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r_out <= w_target;
                    r_mis <= w_mis;
                end
            end
        end

        assign bus.out        = r_out;
        assign bus.out_valid  = r_out_valid;
        assign bus.misaligned = r_mis;
    end else begin : g_comb
        // Clock and reset have no role on the pure combinational path.
        logic w_unused;
        assign w_unused = clk ^ rst_n;

        assign bus.out        = w_target;
        assign bus.out_valid  = bus.in_valid;
        assign bus.misaligned = w_mis;
    end
endmodule

// File: tb/tb_join_shift_jump.sv
// Directed bench for join_shift_jump (registered build) with a reference model.
module tb_join_shift_jump;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   cmp_en = 1'b0;

    join_shift_jump_if bus ();

    join_shift_jump #(.REGISTERED(1'b1), .REGION_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: target = region * 2^28 + (word index * 4 | byte offset).
    function automatic logic [31:0] ref_target(logic se, logic [27:0] a, logic [3:0] b);
        logic [31:0] low;
        low = se ? (32'(a) % 32'h0400_0000) * 32'd4 : 32'(a);
        return (32'(b) * 32'h1000_0000) + low;
    endfunction

    function automatic logic ref_mis(logic se, logic [27:0] a);
        return !se && ((32'(a) % 32'd4) != 32'd0);
    endfunction

    logic [31:0] m_out = '0;
    logic        m_vld = 1'b0;
    logic        m_mis = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out <= '0;
            m_vld <= 1'b0;
            m_mis <= 1'b0;
        end else begin
            m_vld <= bus.in_valid;
            if (bus.in_valid === 1'b1) begin
                m_out <= ref_target(bus.shift_en, bus.in1, bus.in2);
                m_mis <= ref_mis(bus.shift_en, bus.in1);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_out", bus.out, m_out);
            check("cyc_valid", 32'(bus.out_valid), 32'(m_vld));
            check("cyc_mis", 32'(bus.misaligned), 32'(m_mis));
        end
    end

    task automatic set_in(input logic v, input logic se, input logic [27:0] a, input logic [3:0] b);
        bus.in_valid = v;
        bus.shift_en = se;
        bus.in1      = a;
        bus.in2      = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [31:0] o, input logic v, input logic m);
        check({nm, "_out"}, bus.out, o);
        check({nm, "_valid"}, 32'(bus.out_valid), 32'(v));
        check({nm, "_mis"}, 32'(bus.misaligned), 32'(m));
    endtask

    initial begin
        set_in(1'b0, 1'b0, 28'h0, 4'h0);
        #1;
        expect_out("reset", 32'h0, 1'b0, 1'b0);
        cmp_en = 1'b1;
        #11 rst_n = 1'b1;
        tick();

        // 1: region join
        set_in(1'b1, 1'b0, 28'h000_0000, 4'hF);
        tick();
        expect_out("t1", 32'hF000_0000, 1'b1, 1'b0);
        check("t1_model", m_out, 32'hF000_0000);

        // 2: word-index mode
        set_in(1'b1, 1'b1, 28'h040_0003, 4'h1);
        tick();
        expect_out("t2", 32'h1100_000C, 1'b1, 1'b0);
        check("t2_model", m_out, 32'h1100_000C);

        // 3: misaligned byte offset, then same field as a word index
        set_in(1'b1, 1'b0, 28'hABC_DEF1, 4'h0);
        tick();
        expect_out("t3a", 32'h0ABC_DEF1, 1'b1, 1'b1);
        check("t3a_model", 32'(m_mis), 32'd1);
        set_in(1'b1, 1'b1, 28'hABC_DEF1, 4'h0);
        tick();
        expect_out("t3b", 32'h0AF3_7BC4, 1'b1, 1'b0);
        check("t3b_model", m_out, 32'h0AF3_7BC4);

        // 3c: other misaligned residues
        set_in(1'b1, 1'b0, 28'h000_0002, 4'h7);
        tick();
        expect_out("t3c", 32'h7000_0002, 1'b1, 1'b1);
        set_in(1'b1, 1'b0, 28'hFFF_FFFC, 4'h8);
        tick();
        expect_out("t3d", 32'h8FFF_FFFC, 1'b1, 1'b0);

        // 4: hold while idle, inputs X
        set_in(1'b1, 1'b0, 28'h000_0000, 4'hF);
        tick();
        expect_out("t4a", 32'hF000_0000, 1'b1, 1'b0);
        set_in(1'b0, 1'bx, 28'hxxx_xxxx, 4'hx);
        tick();
        expect_out("t4b", 32'hF000_0000, 1'b0, 1'b0);
        tick();
        expect_out("t4c", 32'hF000_0000, 1'b0, 1'b0);

        // 5: async reset between edges, then recovery
        set_in(1'b1, 1'b1, 28'h3FF_FFFF, 4'hF);
        tick();
        expect_out("t5a", 32'hFFFF_FFFC, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        expect_out("t5_async", 32'h0, 1'b0, 1'b0);
        tick();
        expect_out("t5_hold", 32'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        set_in(1'b1, 1'b1, 28'h040_0003, 4'h1);
        tick();
        expect_out("t5b", 32'h1100_000C, 1'b1, 1'b0);

        // 6: back-to-back throughput
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b0, 28'h0, 4'(i));
            tick();
            expect_out($sformatf("t6_%0d", i), 32'(i) << 28, 1'b1, 1'b0);
        end
        set_in(1'b0, 1'b0, 28'h0, 4'h0);
        tick();
        expect_out("t6_end", 32'h3000_0000, 1'b0, 1'b0);
        tick();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
